// File: rtl/scan_test_controller_if.sv
// Bundle of tester-side scan signals: test request/vectors in, scan drive and result out.
// master = the controller, slave = the environment that drives START/vectors and returns SO.
interface scan_test_controller_if #(
  parameter int CHAIN_LEN = 4,
  parameter int ERR_W     = 8
);
  logic                 START;
  logic [CHAIN_LEN-1:0] PATTERN;
  logic [CHAIN_LEN-1:0] EXPECTED;
  logic [CHAIN_LEN-1:0] MASK;
  logic                 SO;
  logic                 SI;
  logic                 SE;
  logic                 BUSY;
  logic                 DONE;
  logic [CHAIN_LEN-1:0] RESPONSE;
  logic                 PASS;
  logic [ERR_W-1:0]     ERR_COUNT;

  modport master (
    input  START, PATTERN, EXPECTED, MASK, SO,
    output SI, SE, BUSY, DONE, RESPONSE, PASS, ERR_COUNT
  );

  modport slave (
    output START, PATTERN, EXPECTED, MASK, SO,
    input  SI, SE, BUSY, DONE, RESPONSE, PASS, ERR_COUNT
  );
endinterface

// File: rtl/scan_test_controller.sv
// Scan test initiator: shift pattern in (MSB first), capture once, shift response out,
// compare against EXPECTED under MASK and count failing tests (saturating).
module scan_test_controller #(
  parameter int CHAIN_LEN = 4,
  parameter int ERR_W     = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  scan_test_controller_if.master  bus,
  output logic [2:0]              dbg_state_o
);
  localparam int CW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(CHAIN_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SHIFT_IN  = 3'd1,
    S_CAPTURE   = 3'd2,
    S_SHIFT_OUT = 3'd3,
    S_DONE      = 3'd4
  } state_e;

  state_e               state_q;
  logic [CW-1:0]        cnt_q;
  logic [CHAIN_LEN-1:0] pat_q, exp_q, mask_q, resp_q;
  logic                 si_q, se_q, busy_q, done_q, pass_q;
  logic [ERR_W-1:0]     err_q;

  logic [CHAIN_LEN-1:0] resp_d;
  logic                 pass_d;

  // Response as it will stand after this edge; lets PASS be valid in the DONE cycle itself.
  always_comb begin
    resp_d = resp_q;
    if (state_q == S_SHIFT_OUT) resp_d[LAST - cnt_q] = bus.SO;
    pass_d = (((resp_d ^ exp_q) & ~mask_q) == '0);
  end

  // Handshake: START is taken only while idle (BUSY low, not DONE); anything else is dropped.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pat_q   <= '0;
      exp_q   <= '0;
      mask_q  <= '0;
      resp_q  <= '0;
      si_q    <= 1'b0;
      se_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          si_q   <= 1'b0;
          se_q   <= 1'b0;
          busy_q <= 1'b0;
          done_q <= 1'b0;
          cnt_q  <= '0;
          if (bus.START) begin
            // pat_q holds the bits still to send, next one always in the MSB.
            si_q    <= bus.PATTERN[CHAIN_LEN-1];
            pat_q   <= bus.PATTERN << 1;
            exp_q   <= bus.EXPECTED;
            mask_q  <= bus.MASK;
            se_q    <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= S_SHIFT_IN;
          end
        end
        S_SHIFT_IN: begin
          if (cnt_q == LAST) begin
            cnt_q   <= '0;
            si_q    <= 1'b0;
            se_q    <= 1'b0;
            state_q <= S_CAPTURE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            si_q  <= pat_q[CHAIN_LEN-1];
            pat_q <= pat_q << 1;
          end
        end
        S_CAPTURE: begin
          cnt_q   <= '0;
          si_q    <= 1'b0;
          se_q    <= 1'b1;
          state_q <= S_SHIFT_OUT;
        end
        S_SHIFT_OUT: begin
          resp_q <= resp_d;
          if (cnt_q == LAST) begin
            cnt_q   <= '0;
            se_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= pass_d;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          cnt_q   <= '0;
          state_q <= S_IDLE;
          if (!pass_q && (err_q != '1)) err_q <= err_q + 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign bus.SI        = si_q;
  assign bus.SE        = se_q;
  assign bus.BUSY      = busy_q;
  assign bus.DONE      = done_q;
  assign bus.RESPONSE  = resp_q;
  assign bus.PASS      = pass_q;
  assign bus.ERR_COUNT = err_q;
  assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_scan_test_controller.sv
// Bench for scan_test_controller with a 4-flop behavioural chain whose capture data is
// the bitwise NOT of its contents; a second instance with ERR_W=2 checks saturation.
module tb_scan_test_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   done_cnt = 0;
  int   err_exp = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  scan_test_controller_if #(.CHAIN_LEN(4), .ERR_W(8)) ifc ();
  scan_test_controller_if #(.CHAIN_LEN(4), .ERR_W(2)) ifc2 ();
  logic [2:0] dbg0, dbg2;

  scan_test_controller #(.CHAIN_LEN(4), .ERR_W(8)) u_dut (
    .CLK(clk), .RST(rst), .bus(ifc.master), .dbg_state_o(dbg0));
  scan_test_controller #(.CHAIN_LEN(4), .ERR_W(2)) u_dut2 (
    .CLK(clk), .RST(rst), .bus(ifc2.master), .dbg_state_o(dbg2));

  // Behavioural chains: shift when SE, otherwise capture the inverse of current contents.
  logic [3:0] chain0 = 4'h0;
  logic [3:0] chain2 = 4'h0;
  always @(posedge clk) begin
    chain0 <= ifc.SE  ? {chain0[2:0], ifc.SI}  : ~chain0;
    chain2 <= ifc2.SE ? {chain2[2:0], ifc2.SI} : ~chain2;
  end
  assign ifc.SO  = chain0[3];
  assign ifc2.SO = chain2[3];

  typedef struct packed {
    logic [3:0] pat;
    logic [3:0] expd;
    logic [3:0] mask;
    logic [3:0] resp;
    logic       pass;
  } vec_t;

  logic [4:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Scoreboard: every DONE pulse of the main DUT pops one expected {RESPONSE, PASS}.
  always @(negedge clk) begin
    if (!rst && ifc.DONE) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected_done: got DONE with empty queue (cycle %0d)", cyc);
      end else begin
        logic [4:0] e;
        e = exp_q.pop_front();
        check("sb_response", {28'h0, ifc.RESPONSE}, {28'h0, e[4:1]});
        check("sb_pass", {31'h0, ifc.PASS}, {31'h0, e[0]});
      end
    end
  end

  function automatic logic model_pass(input logic [3:0] p, input logic [3:0] x, input logic [3:0] m);
    return (((~p ^ x) & ~m) == 4'h0);
  endfunction

  task automatic drive_start(input logic [3:0] p, input logic [3:0] x, input logic [3:0] m);
    @(posedge clk); #1;
    ifc.START = 1'b1; ifc.PATTERN = p; ifc.EXPECTED = x; ifc.MASK = m;
    @(posedge clk); #1;
    ifc.START = 1'b0;
  endtask

  // Table entry test: start, wait (bounded) for DONE, then check ERR_COUNT in the next cycle.
  task automatic run_test(input vec_t v);
    bit got;
    exp_q.push_back({v.resp, v.pass});
    if (!v.pass && err_exp < 255) err_exp++;
    drive_start(v.pat, v.expd, v.mask);
    got = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ifc.DONE) begin got = 1; break; end
    end
    check("done_seen", {31'h0, got}, 32'h1);
    @(posedge clk); @(negedge clk);
    check("err_count", {24'h0, ifc.ERR_COUNT}, err_exp);
  endtask

  // Cycle-exact test; disturb pulses START mid-shift (with a new PATTERN) and in the DONE cycle.
  task automatic run_checked(input logic [3:0] p, input logic [3:0] x, input logic [3:0] m,
                             input bit disturb);
    logic exp_si, exp_se;
    exp_q.push_back({~p, model_pass(p, x, m)});
    if (!model_pass(p, x, m) && err_exp < 255) err_exp++;
    drive_start(p, x, m);
    for (int c = 1; c <= 13; c++) begin
      if (disturb && c == 2) begin ifc.START = 1'b1; ifc.PATTERN = ~p; end
      if (disturb && c == 3) ifc.START = 1'b0;
      if (disturb && c == 10) ifc.START = 1'b1;
      if (disturb && c == 11) ifc.START = 1'b0;
      exp_se = ((c >= 1 && c <= 4) || (c >= 6 && c <= 9));
      exp_si = (c <= 4) ? p[4-c] : 1'b0;
      @(negedge clk);
      check("seq_se", {31'h0, ifc.SE}, {31'h0, exp_se});
      check("seq_si", {31'h0, ifc.SI}, {31'h0, exp_si});
      check("seq_busy", {31'h0, ifc.BUSY}, (c <= 9) ? 32'h1 : 32'h0);
      check("seq_done", {31'h0, ifc.DONE}, (c == 10) ? 32'h1 : 32'h0);
      if (c == 11) check("seq_err_count", {24'h0, ifc.ERR_COUNT}, err_exp);
      @(posedge clk); #1;
    end
  endtask

  vec_t tbl[6];

  initial begin
    int d0, n, last, err2;
    bit prev_done;
    ifc.START = 0; ifc.PATTERN = 0; ifc.EXPECTED = 0; ifc.MASK = 0;
    ifc2.START = 0; ifc2.PATTERN = 0; ifc2.EXPECTED = 0; ifc2.MASK = 0;

    tbl[0] = '{pat: 4'b1010, expd: 4'b0101, mask: 4'b0000, resp: 4'b0101, pass: 1'b1};
    tbl[1] = '{pat: 4'b0011, expd: 4'b1111, mask: 4'b0000, resp: 4'b1100, pass: 1'b0};
    tbl[2] = '{pat: 4'b0011, expd: 4'b1111, mask: 4'b0011, resp: 4'b1100, pass: 1'b1};
    tbl[3] = '{pat: 4'b1111, expd: 4'b1111, mask: 4'b1111, resp: 4'b0000, pass: 1'b1};
    tbl[4] = '{pat: 4'b0110, expd: 4'b1001, mask: 4'b0000, resp: 4'b1001, pass: 1'b1};
    tbl[5] = '{pat: 4'b0000, expd: 4'b0000, mask: 4'b1110, resp: 4'b1111, pass: 1'b0};

    // Reset values
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_se", {31'h0, ifc.SE}, 32'h0);
    check("rst_si", {31'h0, ifc.SI}, 32'h0);
    check("rst_busy", {31'h0, ifc.BUSY}, 32'h0);
    check("rst_done", {31'h0, ifc.DONE}, 32'h0);
    check("rst_response", {28'h0, ifc.RESPONSE}, 32'h0);
    check("rst_pass", {31'h0, ifc.PASS}, 32'h0);
    check("rst_err_count", {24'h0, ifc.ERR_COUNT}, 32'h0);
    check("rst_state", {29'h0, dbg0}, 32'h0);

    // Scenario 1: cycle-exact sequence
    run_checked(4'b1010, 4'b0101, 4'b0000, 1'b0);

    // Table of vectors, plus a few random ones checked against the model
    for (int i = 0; i < 6; i++) run_test(tbl[i]);
    for (int i = 0; i < 4; i++) begin
      vec_t v;
      v.pat  = 4'($urandom_range(0, 15));
      v.expd = 4'($urandom_range(0, 15));
      v.mask = 4'($urandom_range(0, 15));
      v.resp = ~v.pat;
      v.pass = model_pass(v.pat, v.expd, v.mask);
      run_test(v);
    end

    // Scenario 3: ignored STARTs and mid-test PATTERN change
    d0 = done_cnt;
    run_checked(4'b1100, 4'b0011, 4'b0000, 1'b1);
    check("one_done_per_start", done_cnt - d0, 32'h1);

    // Scenario 4: reset in SHIFT_IN cycle 3, with a simultaneous START
    @(posedge clk); #1;
    ifc.START = 1'b1; ifc.PATTERN = 4'b1010; ifc.EXPECTED = 4'b0000; ifc.MASK = 4'b0000;
    @(posedge clk); #1 ifc.START = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; ifc.START = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; ifc.START = 1'b0;
    err_exp = 0;
    @(negedge clk);
    check("midrst_se", {31'h0, ifc.SE}, 32'h0);
    check("midrst_busy", {31'h0, ifc.BUSY}, 32'h0);
    check("midrst_response", {28'h0, ifc.RESPONSE}, 32'h0);
    check("midrst_err_count", {24'h0, ifc.ERR_COUNT}, 32'h0);
    @(negedge clk);
    check("midrst_no_queue", {31'h0, ifc.BUSY}, 32'h0);
    run_checked(4'b1010, 4'b0101, 4'b0000, 1'b0);

    // Scenario 5: START held with a failing vector on the ERR_W=2 instance
    @(posedge clk); #1;
    ifc2.START = 1'b1; ifc2.PATTERN = 4'b0011; ifc2.EXPECTED = 4'b1111; ifc2.MASK = 4'b0000;
    n = 0; last = 0; prev_done = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (prev_done) begin
        err2 = (n < 3) ? n : 3;
        check("sat_err_count", {30'h0, ifc2.ERR_COUNT}, err2);
        if (n == 4) break;
      end
      prev_done = ifc2.DONE;
      if (ifc2.DONE) begin
        n++;
        check("sat_response", {28'h0, ifc2.RESPONSE}, 32'hC);
        check("sat_pass", {31'h0, ifc2.PASS}, 32'h0);
        if (n > 1) check("sat_period", cyc - last, 32'd11);
        last = cyc;
      end
    end
    ifc2.START = 1'b0;
    check("sat_done_pulses", n, 32'd4);

    repeat (3) @(posedge clk);
    check("sb_drained", exp_q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/scan_test_controller.md
# scan_test_controller

Tester-side initiator for the serial scan interface. It drives `SI`/`SE` into a scan-wrapped circuit under test and receives that circuit's `SO`. Per test, it shifts a stimulus pattern into the chain, issues one capture cycle, shifts the response out and compares it against an expected value, with per-bit masking. It sits beside the scan-wrapped CUT and shares its `CLK`.

## Interface
- `CHAIN_LEN`, default 4: number of scan flops in the target chain (≥2).
- `ERR_W`, default 8: width of the failing-test counter.

- `CLK` input 1: single clock. All logic is on the rising edge.
- `RST` input 1: synchronous, active-high reset.
- `START` input 1: start-test request. Sampled only in IDLE.
- `PATTERN` input `CHAIN_LEN`: stimulus. Bit i is loaded into chain position i. Latched at accepted `START`.
- `EXPECTED` input `CHAIN_LEN`: expected captured response. Latched at accepted `START`.
- `MASK` input `CHAIN_LEN`: 1 = don't-care bit. Latched at accepted `START`.
- `SO` input 1: scan out of the target chain (chain position `CHAIN_LEN-1`).
- `SI` output 1: scan in to the target chain (feeds chain position 0).
- `SE` output 1: scan enable. 1 = shift, 0 = functional/capture.
- `BUSY` output 1: high from the cycle after accepted `START` until DONE state.
- `DONE` output 1: one-cycle pulse. `RESPONSE` and `PASS` are valid from this cycle.
- `RESPONSE` output `CHAIN_LEN`: unloaded chain contents. Bit i = captured value of position i.
- `PASS` output 1: `((RESPONSE ^ EXPECTED) & ~MASK) == 0`.
- `ERR_COUNT` output `ERR_W`: number of failing tests since reset. Saturates at all-ones.

## Operation
- Chain model assumed by this block:
  - While `SE`=1, each edge does pos0←SI and pos i←pos i-1.
  - While `SE`=0, each edge loads the CUT outputs into the flops.
  - `SO` = pos `CHAIN_LEN-1`.
- FSM states: IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, DONE.
- Bit counter: `$clog2(CHAIN_LEN)` bits, cleared on every state entry.

- IDLE:
  - Outputs: `SE`=0, `SI`=0, `BUSY`=0.
  - `START`=1 at an edge latches `PATTERN`/`EXPECTED`/`MASK` and moves to SHIFT_IN.
- SHIFT_IN, `CHAIN_LEN` cycles:
  - `SE`=1.
  - In shift cycle c (c=0..`CHAIN_LEN-1`), `SI`=`PATTERN[CHAIN_LEN-1-c]`, so MSB goes first.
  - After the last cycle, move to CAPTURE.
- CAPTURE, exactly 1 cycle:
  - `SE`=0, `SI`=0.
  - The chain captures at the closing edge.
  - Move to SHIFT_OUT.
- SHIFT_OUT, `CHAIN_LEN` cycles:
  - `SE`=1, `SI`=0.
  - At the edge ending cycle c, `SO` is sampled into `RESPONSE[CHAIN_LEN-1-c]`.
  - After the last cycle, move to DONE.
- DONE, 1 cycle:
  - `DONE`=1, `BUSY`=0, `SE`=0.
  - `PASS` is computed from the final `RESPONSE`.
  - If `PASS`=0, `ERR_COUNT` increments at this edge unless already all-ones.
  - Return to IDLE.
- `RESPONSE` and `PASS` hold their values until the next DONE. `RESPONSE` updates bit-by-bit during SHIFT_OUT.

- Boundary cases:
  - `START` while not in IDLE, including in the DONE cycle, is ignored and not queued.
  - Changes to `PATTERN`/`EXPECTED`/`MASK` after acceptance have no effect.
  - All-ones `MASK` always gives `PASS`=1.
  - `ERR_COUNT` at all-ones stays all-ones on further failures.

## Timing
- Reset values (`RST`=1 at an edge, any state, including mid-shift):
  - Next cycle: state IDLE, `SE`=0, `SI`=0, `BUSY`=0, `DONE`=0, `RESPONSE`=0, `PASS`=0, `ERR_COUNT`=0.
  - A partially shifted chain is abandoned. Its contents are undefined to the bench.
  - `RST` overrides a simultaneous `START`.
- Latency: with `START` accepted at edge 0:
  - SHIFT_IN occupies cycles 1..L.
  - CAPTURE occupies cycle L+1.
  - SHIFT_OUT occupies cycles L+2..2L+1.
  - `DONE` is high in cycle 2L+2.
  - For L=4, `DONE` is in cycle 10.
- Back-to-back: `START` held high gives a new test every 2L+3 cycles (DONE→IDLE→accept).
- All outputs are registered. No combinational path from `SO` or `START` to any output.

## Test plan
Bench setup: L=4, behavioural 4-flop chain whose capture data = bitwise NOT of its current contents.

1. Reset, then `START` with `PATTERN`=1010, `EXPECTED`=0101, `MASK`=0000 → `SI` sequence 1,0,1,0 on cycles 1–4; `SE`=0 only in cycle 5; `DONE` in cycle 10; `RESPONSE`=0101, `PASS`=1, `ERR_COUNT`=0.
2. `PATTERN`=0011, `EXPECTED`=1111, `MASK`=0000 → `RESPONSE`=1100, `PASS`=0, `ERR_COUNT`=1. Repeat with `MASK`=0011 → `PASS`=1, `ERR_COUNT` stays 1.
3. `START` pulsed during SHIFT_IN and during the DONE cycle → ignored; exactly one `DONE` pulse per accepted start; `PATTERN` changed mid-test does not alter the `SI` sequence.
4. `RST` asserted in cycle 3 of SHIFT_IN → next cycle `SE`=0, `BUSY`=0, `RESPONSE`=0, `ERR_COUNT`=0. A fresh test then passes as in scenario 1.
5. `START` held high with a failing vector and `ERR_W`=2 override → `DONE` every 11 cycles; `ERR_COUNT` goes 1,2,3,3 (saturates).
